// File: rtl/sensor_conditioner.sv
// Conditions two raw, bouncy presence sensors into clean levels, one-shot edge
// pulses that never coincide, and stuck-high flags.
module sensor_conditioner #(
  parameter int DB_CYCLES    = 16,
  parameter int STUCK_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic sen1,
  input  logic sen2,
  output logic enter_p,
  output logic exit_p,
  output logic sen1_clean,
  output logic sen2_clean,
  output logic stuck1,
  output logic stuck2
);

  localparam logic [4:0]  DB_LAST   = 5'(DB_CYCLES - 1);
  localparam logic [10:0] STUCK_MAX = 11'(STUCK_CYCLES);

  // Bit 0 is the entry channel (sen1), bit 1 the exit channel (sen2).
  logic [1:0]  meta;
  logic [1:0]  sync;
  logic [1:0]  clean;
  logic [1:0]  clean_q;
  logic [1:0]  rise;
  logic [1:0]  stuck;
  logic [4:0]  db_cnt  [2];
  logic [10:0] st_cnt  [2];
  logic [10:0] st_next [2];
  logic        pending;

  // NOTE: every always_comb output gets a default before any condition, so no latch can be inferred.
  always_comb begin
    rise = clean & ~clean_q;
    for (int i = 0; i < 2; i++) begin
      st_next[i] = '0;
      if (clean[i]) begin
        st_next[i] = (st_cnt[i] == STUCK_MAX) ? st_cnt[i] : st_cnt[i] + 11'd1;
      end
    end
  end

  // NOTE: state uses non-blocking assignments only; the synchronizer is reset as
  // well, so a sensor already high at release is treated as a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta    <= '0;
      sync    <= '0;
      clean   <= '0;
      clean_q <= '0;
      stuck   <= '0;
      pending <= 1'b0;
      enter_p <= 1'b0;
      exit_p  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
        st_cnt[i] <= '0;
      end
    end else begin
      meta    <= {sen2, sen1};
      sync    <= meta;
      clean_q <= clean;
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == clean[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          clean[i]  <= sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 5'd1;
        end
        st_cnt[i] <= st_next[i];
        stuck[i]  <= (st_next[i] == STUCK_MAX);
      end
      // On a simultaneous rise the entry wins; the exit is deferred by one cycle.
      enter_p <= rise[0];
      exit_p  <= pending | (rise[1] & ~rise[0]);
      pending <= rise[0] & rise[1];
    end
  end

  assign sen1_clean = clean[0];
  assign sen2_clean = clean[1];
  assign stuck1     = stuck[0];
  assign stuck2     = stuck[1];

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: vector table, directed corner sequences and a
// long random-bounce run, all checked against a sample-history reference model.
module tb_sensor_conditioner;

  localparam int DB = 16;
  localparam int ST = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sen1 = 1'b0;
  logic sen2 = 1'b0;
  logic enter_p, exit_p, sen1_clean, sen2_clean, stuck1, stuck2;

  int total = 0;
  int bad   = 0;

  sensor_conditioner #(.DB_CYCLES(DB), .STUCK_CYCLES(ST)) dut (
    .clk        (clk),
    .rst        (rst),
    .sen1       (sen1),
    .sen2       (sen2),
    .enter_p    (enter_p),
    .exit_p     (exit_p),
    .sen1_clean (sen1_clean),
    .sen2_clean (sen2_clean),
    .stuck1     (stuck1),
    .stuck2     (stuck2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: a level flips once the last DB synchronized samples
  // (raw samples taken two edges earlier) all disagree with it.
  bit m_hist [2][DB+2];
  bit m_clean [2];
  bit m_rose  [2];
  bit m_rose_now [2];
  bit m_raw   [2];
  bit m_all;
  bit m_pend;
  int m_run   [2];
  bit e_enter, e_exit;
  bit e_stuck [2];
  int m_rises [2];
  bit count_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < DB + 2; k++) m_hist[c][k] = 1'b0;
        m_clean[c] = 1'b0;
        m_rose[c]  = 1'b0;
        m_run[c]   = 0;
        e_stuck[c] = 1'b0;
      end
      m_pend  = 1'b0;
      e_enter = 1'b0;
      e_exit  = 1'b0;
    end else begin
      m_raw[0] = sen1;
      m_raw[1] = sen2;
      e_enter = m_rose[0];
      e_exit  = m_pend || (m_rose[1] && !m_rose[0]);
      m_pend  = m_rose[0] && m_rose[1];
      for (int c = 0; c < 2; c++) begin
        m_run[c]   = m_clean[c] ? m_run[c] + 1 : 0;
        e_stuck[c] = (m_run[c] >= ST);
        for (int k = DB + 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[c][0] = m_raw[c];
        m_all = 1'b1;
        for (int k = 2; k < DB + 2; k++) if (m_hist[c][k] == m_clean[c]) m_all = 1'b0;
        m_rose_now[c] = m_all && !m_clean[c];
        if (m_all) m_clean[c] = !m_clean[c];
        m_rose[c] = m_rose_now[c];
        if (m_rose_now[c] && count_en) m_rises[c]++;
      end
    end
  end

  // Per-cycle comparison against the model, plus pulse-shape rules.
  bit enter_q = 1'b0;
  bit exit_q  = 1'b0;
  int dut_enters = 0;
  int dut_exits  = 0;

  always @(negedge clk) begin
    check("enter_p",    enter_p,    e_enter);
    check("exit_p",     exit_p,     e_exit);
    check("sen1_clean", sen1_clean, m_clean[0]);
    check("sen2_clean", sen2_clean, m_clean[1]);
    check("stuck1",     stuck1,     e_stuck[0]);
    check("stuck2",     stuck2,     e_stuck[1]);
    check("pulse_overlap", enter_p & exit_p, 0);
    check("enter_width",   enter_p & enter_q, 0);
    check("exit_width",    exit_p & exit_q, 0);
    enter_q = enter_p;
    exit_q  = exit_p;
    if (count_en && enter_p) dut_enters++;
    if (count_en && exit_p)  dut_exits++;
  end

  typedef struct {
    bit s1;
    bit s2;
    int hold;
    int n_enter;
    int n_exit;
    bit c1;
    bit c2;
  } vec_t;

  vec_t tbl [7];

  int  first_c, ent_at, ent_n, ex_at, ex_n, both_n;
  int  r_at, s_at, f_at;
  bit  st_f, st_f1, seen, b1, b2;
  int  seg_len, left;

  initial begin
    tbl[0] = '{s1:1, s2:0, hold:30, n_enter:1, n_exit:0, c1:1, c2:0};
    tbl[1] = '{s1:1, s2:1, hold:30, n_enter:0, n_exit:1, c1:1, c2:1};
    tbl[2] = '{s1:0, s2:1, hold:30, n_enter:0, n_exit:0, c1:0, c2:1};
    tbl[3] = '{s1:0, s2:0, hold:30, n_enter:0, n_exit:0, c1:0, c2:0};
    tbl[4] = '{s1:1, s2:1, hold:30, n_enter:1, n_exit:1, c1:1, c2:1};
    tbl[5] = '{s1:0, s2:0, hold:10, n_enter:0, n_exit:0, c1:1, c2:1};
    tbl[6] = '{s1:0, s2:0, hold:20, n_enter:0, n_exit:0, c1:0, c2:0};

    repeat (3) tick();
    check("reset_outputs", {enter_p, exit_p, sen1_clean, sen2_clean, stuck1, stuck2}, 0);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      sen1 = tbl[v].s1;
      sen2 = tbl[v].s2;
      ent_n = 0;
      ex_n  = 0;
      for (int k = 0; k < tbl[v].hold; k++) begin
        tick();
        if (enter_p) ent_n++;
        if (exit_p)  ex_n++;
      end
      check($sformatf("vec%0d_enters", v), ent_n, tbl[v].n_enter);
      check($sformatf("vec%0d_exits", v),  ex_n,  tbl[v].n_exit);
      check($sformatf("vec%0d_clean1", v), sen1_clean, tbl[v].c1);
      check($sformatf("vec%0d_clean2", v), sen2_clean, tbl[v].c2);
    end

    // Clean level lands on the DB+2-th edge counting the sampling edge; pulse follows.
    sen1 = 1'b1;
    first_c = 0; ent_at = 0; ent_n = 0; ex_n = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (sen1_clean && first_c == 0) first_c = k;
      if (enter_p) begin
        ent_n++;
        if (ent_at == 0) ent_at = k;
      end
      if (exit_p) ex_n++;
    end
    check("lat_clean", first_c, DB + 2);
    check("lat_enter", ent_at, DB + 3);
    check("lat_enter_count", ent_n, 1);
    check("lat_no_exit", ex_n, 0);
    sen1 = 1'b0;
    repeat (30) tick();

    // Bounce every 3 cycles must never reach the clean level.
    seen = 1'b0; ex_n = 0;
    for (int i = 0; i < 65; i++) begin
      if (i < 40 && i % 3 == 0) sen2 = ~sen2;
      if (i == 40) sen2 = 1'b0;
      tick();
      if (sen2_clean) seen = 1'b1;
      if (exit_p) ex_n++;
    end
    check("bounce_clean2", seen, 0);
    check("bounce_exits", ex_n, 0);

    // Simultaneous rise: entry first, exit one cycle later.
    sen1 = 1'b1; sen2 = 1'b1;
    ent_at = 0; ex_at = 0; both_n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (enter_p && ent_at == 0) ent_at = k;
      if (exit_p && ex_at == 0) ex_at = k;
      if (enter_p && exit_p) both_n++;
    end
    check("simul_enter_at", ent_at, DB + 3);
    check("simul_exit_at", ex_at, DB + 4);
    check("simul_overlap", both_n, 0);
    sen1 = 1'b0; sen2 = 1'b0;
    repeat (30) tick();

    // Stuck flag: rises after ST increments of the high counter, drops the
    // cycle after the clean level falls.
    sen1 = 1'b1;
    r_at = 0; s_at = 0;
    for (int k = 1; k <= 1100; k++) begin
      tick();
      if (sen1_clean && r_at == 0) r_at = k;
      if (stuck1 && s_at == 0) s_at = k;
    end
    check("stuck_seen", stuck1, 1);
    check("stuck_delay", s_at - r_at, ST);
    sen1 = 1'b0;
    f_at = 0; st_f = 1'b0; st_f1 = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (!sen1_clean && f_at == 0) begin
        f_at = k;
        st_f = stuck1;
      end else if (f_at != 0 && k == f_at + 1) begin
        st_f1 = stuck1;
      end
    end
    check("stuck_fall_clean", f_at, DB + 2);
    check("stuck_held_at_fall", st_f, 1);
    check("stuck_drop_after", st_f1, 0);

    // Reset between a simultaneous entry and its deferred exit.
    sen1 = 1'b1; sen2 = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (enter_p) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_enter_seen", seen, 1);
    #1 rst = 1'b1;
    sen1 = 1'b0; sen2 = 1'b0;
    #1 check("rst_async_zero", {enter_p, exit_p, sen1_clean, sen2_clean, stuck1, stuck2}, 0);
    tick();
    check("rst_hold_zero", {enter_p, exit_p, sen1_clean, sen2_clean, stuck1, stuck2}, 0);
    tick();
    rst = 1'b0;
    ex_n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (exit_p) ex_n++;
    end
    check("rst_no_exit", ex_n, 0);

    // Input already high at reset release is a fresh edge.
    rst = 1'b1; sen1 = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    ent_at = 0; ent_n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (enter_p) begin
        ent_n++;
        if (ent_at == 0) ent_at = k;
      end
    end
    check("relhigh_enter_at", ent_at, DB + 3);
    check("relhigh_enter_count", ent_n, 1);
    sen1 = 1'b0;
    repeat (30) tick();

    // Random bounce segments on both sensors.
    m_rises[0] = 0; m_rises[1] = 0;
    dut_enters = 0; dut_exits = 0;
    count_en = 1'b1;
    left = 10000;
    while (left > 0) begin
      seg_len = $urandom_range(80, 1);
      b1 = 1'($urandom_range(1, 0));
      b2 = 1'($urandom_range(1, 0));
      for (int i = 0; i < seg_len; i++) begin
        if (b1) begin
          if ($urandom_range(3, 0) == 0) sen1 = ~sen1;
        end else if (i == 0) begin
          sen1 = 1'($urandom_range(1, 0));
        end
        if (b2) begin
          if ($urandom_range(3, 0) == 0) sen2 = ~sen2;
        end else if (i == 0) begin
          sen2 = 1'($urandom_range(1, 0));
        end
        tick();
        left--;
      end
    end
    sen1 = 1'b0; sen2 = 1'b0;
    repeat (40) tick();
    count_en = 1'b0;
    check("rand_enter_count", dut_enters, m_rises[0]);
    check("rand_exit_count",  dut_exits,  m_rises[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
